// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
//   After an arm, this block captures (time_curr, sig) at a programmed start time and then
//   once per programmed period. It stops after cfg_count samples, or never if cfg_count is 0.
//   Each capture goes out through a one-deep valid/ready output register to the ADC sink.
//
// Ports
//   clk, rst_n        system clock; asynchronous active-low reset
//   time_curr         emulated time, unsigned fixed point (time_bits wide)
//   time_valid        time_curr is valid this cycle
//   sig               signed analog sample value
//   cfg_start         time of the first sample, latched on arm
//   cfg_period        sample period, latched on arm; 0 behaves as 1 LSB
//   cfg_count         number of samples, 0 = unlimited; latched on arm
//   arm, abort        start a run (only in IDLE) / end a run immediately
//   samp_valid/ready  output handshake; samp_time/samp_data hold the captured pair
//   busy              a run is in progress
//   done              one-cycle completion pulse (combinational, so it can coincide with
//                     acceptance of the final sample)
//   overrun           sticky flag: a capture was dropped; cleared on arm
module adc_sample_scheduler #(
  parameter int unsigned sig_bits   = 16,
  parameter int unsigned count_bits = 16,
  parameter int unsigned time_bits  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [time_bits-1:0]        time_curr,
  input  logic                        time_valid,
  input  logic signed [sig_bits-1:0]  sig,
  input  logic [time_bits-1:0]        cfg_start,
  input  logic [time_bits-1:0]        cfg_period,
  input  logic [count_bits-1:0]       cfg_count,
  input  logic                        arm,
  input  logic                        abort,
  output logic                        samp_valid,
  input  logic                        samp_ready,
  output logic [time_bits-1:0]        samp_time,
  output logic signed [sig_bits-1:0]  samp_data,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [time_bits-1:0]         t_next_q, t_next_d;
  logic [time_bits-1:0]         period_q, period_d;
  logic [count_bits-1:0]        remaining_q, remaining_d;
  logic                         unlimited_q, unlimited_d;
  logic                         samp_valid_q, samp_valid_d;
  logic [time_bits-1:0]         samp_time_q, samp_time_d;
  logic signed [sig_bits-1:0]   samp_data_q, samp_data_d;
  logic                         busy_q, busy_d;
  logic                         overrun_q, overrun_d;
  logic                         done_c;

  logic                         hit;
  logic                         accept;
  logic [time_bits:0]           t_sum;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      t_next_q     <= '0;
      period_q     <= '0;
      remaining_q  <= '0;
      unlimited_q  <= 1'b0;
      samp_valid_q <= 1'b0;
      samp_time_q  <= '0;
      samp_data_q  <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_next_q     <= t_next_d;
      period_q     <= period_d;
      remaining_q  <= remaining_d;
      unlimited_q  <= unlimited_d;
      samp_valid_q <= samp_valid_d;
      samp_time_q  <= samp_time_d;
      samp_data_q  <= samp_data_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state, capture and handshake logic
  always_comb begin
    state_d      = state_q;
    t_next_d     = t_next_q;
    period_d     = period_q;
    remaining_d  = remaining_q;
    unlimited_d  = unlimited_q;
    samp_valid_d = samp_valid_q;
    samp_time_d  = samp_time_q;
    samp_data_d  = samp_data_q;
    overrun_d    = overrun_q;
    done_c       = 1'b0;

    accept = samp_valid_q & samp_ready;
    hit    = time_valid & (time_curr >= t_next_q);
    // One extra bit catches the end of the time range instead of wrapping
    t_sum  = {1'b0, t_next_q} + {1'b0, period_q};

    if (accept) begin
      samp_valid_d = 1'b0;
    end

    if (abort) begin
      state_d      = ST_IDLE;
      samp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            t_next_d    = cfg_start;
            period_d    = (cfg_period == '0) ? time_bits'(1) : cfg_period;
            remaining_d = cfg_count;
            unlimited_d = (cfg_count == '0);
            overrun_d   = 1'b0;
            state_d     = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (hit) begin
            // The register is free, or its current sample leaves this cycle
            if (!samp_valid_q || samp_ready) begin
              samp_valid_d = 1'b1;
              samp_time_d  = time_curr;
              samp_data_d  = sig;
            end else begin
              overrun_d = 1'b1;
            end
            // A dropped hit still uses up one sample slot and one period
            if (!unlimited_q) begin
              remaining_d = remaining_q - count_bits'(1);
            end
            if (!unlimited_q && (remaining_q == count_bits'(1))) begin
              state_d = ST_DRAIN;
            end else if (t_sum[time_bits]) begin
              state_d = ST_DRAIN;
            end else begin
              t_next_d = t_sum[time_bits-1:0];
            end
          end
        end
        ST_DRAIN: begin
          if (!samp_valid_q || samp_ready) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign samp_valid = samp_valid_q;
  assign samp_time  = samp_time_q;
  assign samp_data  = samp_data_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign done       = done_c;

endmodule
